// File: rtl/clk_mon_if.sv
// clk_mon_if: groups the monitored input and the measurement outputs of clk_mon.
//   sig_in     : monitored slow clock (driven by master)
//   period     : last measured period in clk cycles
//   high_time  : last measured high phase in clk cycles
//   meas_valid : one-cycle pulse when period/high_time update
//   err        : one-cycle pulse for an out-of-tolerance period
//   stuck      : one-cycle pulse on timeout
//   locked     : level, enough consecutive good periods seen
interface clk_mon_if #(parameter int CW = 16);
   logic          sig_in;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          meas_valid;
   logic          err;
   logic          stuck;
   logic          locked;
   modport master (output sig_in, input period, high_time, meas_valid, err, stuck, locked);
   modport slave  (input sig_in, output period, high_time, meas_valid, err, stuck, locked);
endinterface

// File: rtl/clk_mon.sv
// clk_mon: measures period and high phase of an asynchronous slow clock, flags
// out-of-tolerance periods and timeouts, and reports lock.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of clk_mon_if (sig_in in, measurement results out)
module clk_mon #(
   parameter int EXP_PERIOD = 5000,
   parameter int TOL        = 8,
   parameter int LOCK_N     = 2,
   parameter int CW         = 16
) (
   input logic      clk,
   input logic      rst,
   clk_mon_if.slave bus
);
   typedef enum logic {IDLE, MEAS} state_t;
   localparam int GW = $clog2(LOCK_N + 1);
   localparam int LO = EXP_PERIOD - TOL;
   localparam int HI = EXP_PERIOD + TOL;
   state_t        state;
   logic          s1, s2, s3;
   logic [CW-1:0] pcnt, hcnt;
   logic [GW-1:0] good;
   logic          rise, good_p, tout;
   assign rise   = s2 & ~s3;
   // judged on the pre-reset count of the rise cycle
   assign good_p = int'(pcnt) >= LO && int'(pcnt) <= HI;
   assign tout   = pcnt == CW'(2 * EXP_PERIOD);
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         s1             <= 1'b0;
         s2             <= 1'b0;
         s3             <= 1'b0;
         pcnt           <= '0;
         hcnt           <= '0;
         good           <= '0;
         bus.period     <= '0;
         bus.high_time  <= '0;
         bus.meas_valid <= 1'b0;
         bus.err        <= 1'b0;
         bus.stuck      <= 1'b0;
         bus.locked     <= 1'b0;
      end else begin
         s1             <= bus.sig_in;
         s2             <= s1;
         s3             <= s2;
         bus.meas_valid <= 1'b0;
         bus.err        <= 1'b0;
         bus.stuck      <= 1'b0;
         if (state == IDLE) begin
            if (rise) begin
               state <= MEAS;
               pcnt  <= CW'(1);
               hcnt  <= CW'(1);
            end
         end else if (rise) begin
            bus.period     <= pcnt;
            bus.high_time  <= hcnt;
            bus.meas_valid <= 1'b1;
            bus.err        <= ~good_p;
            pcnt           <= CW'(1);
            hcnt           <= CW'(1);
            if (good_p) begin
               good <= (int'(good) == LOCK_N) ? good : good + GW'(1);
               if (int'(good) + 1 >= LOCK_N) bus.locked <= 1'b1;
            end else begin
               good       <= '0;
               bus.locked <= 1'b0;
            end
         end else if (tout) begin
            // rise has priority, so a timeout only fires when no edge arrived
            state      <= IDLE;
            bus.stuck  <= 1'b1;
            bus.locked <= 1'b0;
            good       <= '0;
         end else begin
            pcnt <= pcnt + CW'(1);
            if (s2) hcnt <= hcnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_clk_mon.sv
// tb_clk_mon: scoreboard bench for clk_mon with directed divided-clock waveforms.
module tb_clk_mon;
   typedef struct {
      int mv;
      int st;
      int per;
      int ht;
      int er;
      int lk;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   exp_t sb[$];
   clk_mon_if #(.CW(16)) bus ();
   clk_mon dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic void chk(string name, int act, int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endfunction
   function automatic void push(int mv, int st, int per, int ht, int er, int lk);
      exp_t e;
      e.mv  = mv;
      e.st  = st;
      e.per = per;
      e.ht  = ht;
      e.er  = er;
      e.lk  = lk;
      sb.push_back(e);
   endfunction
   task automatic per_wave(int h, int l);
      bus.sig_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask
   task automatic check_reset(string tag);
      chk({tag, "_period"}, int'(bus.period), 0);
      chk({tag, "_high_time"}, int'(bus.high_time), 0);
      chk({tag, "_meas_valid"}, int'(bus.meas_valid), 0);
      chk({tag, "_err"}, int'(bus.err), 0);
      chk({tag, "_stuck"}, int'(bus.stuck), 0);
      chk({tag, "_locked"}, int'(bus.locked), 0);
   endtask
   always @(negedge clk) begin
      if (!rst && (bus.meas_valid || bus.stuck)) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("meas_valid", int'(bus.meas_valid), e.mv);
            chk("stuck", int'(bus.stuck), e.st);
            chk("period", int'(bus.period), e.per);
            chk("high_time", int'(bus.high_time), e.ht);
            chk("err", int'(bus.err), e.er);
            chk("locked", int'(bus.locked), e.lk);
         end
      end
   end
   initial begin
      bus.sig_in = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("rst0");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      // first rise only arms; each result appears at the following rise
      per_wave(2500, 2500); push(1, 0, 5000, 2500, 0, 0);
      per_wave(2500, 2500); push(1, 0, 5000, 2500, 0, 1);
      per_wave(2500, 2509); push(1, 0, 5009, 2500, 1, 0);
      per_wave(2500, 2500); push(1, 0, 5000, 2500, 0, 0);
      per_wave(2500, 2500); push(1, 0, 5000, 2500, 0, 1);
      per_wave(2500, 2508); push(1, 0, 5008, 2500, 0, 1);
      per_wave(2500, 2492); push(1, 0, 4992, 2500, 0, 1);
      per_wave(2500, 2491); push(1, 0, 4991, 2500, 1, 0);
      per_wave(3000, 2000); push(1, 0, 5000, 3000, 0, 0);
      // closing rise then held high: timeout keeps the last measurement
      push(0, 1, 5000, 3000, 0, 0);
      bus.sig_in = 1'b1;
      repeat (10100) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (100) @(negedge clk);
      per_wave(2500, 2500); push(1, 0, 5000, 2500, 0, 0);
      // reset 1200 cycles into a period, while sig_in is low
      bus.sig_in = 1'b1;
      repeat (1000) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (200) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("rst1");
      repeat (3800) @(negedge clk);
      per_wave(2500, 2500); push(1, 0, 5000, 2500, 0, 0);
      bus.sig_in = 1'b1;
      repeat (20) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (20) @(negedge clk);
      chk("pending_expectations", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
